// File: rtl/tel_char_feeder.sv
// Keypad input stage for the phone controller: two character FIFOs (caller, callee)
// drained one character at a time towards tel, only on the side whose turn it is.
module tel_char_feeder #(
    parameter  int DEPTH = 8,
    parameter  int GAP   = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          callerValid_i,
    input  logic [7:0]    callerChar_i,
    output logic          callerReady_o,
    input  logic          calleeValid_i,
    input  logic [7:0]    calleeChar_i,
    output logic          calleeReady_o,
    input  logic [63:0]   statusMsg_i,
    output logic [7:0]    charSent_o,
    output logic          sendCharCaller_o,
    output logic          sendCharCallee_o,
    output logic [CW-1:0] callerCount_o,
    output logic [CW-1:0] calleeCount_o
);

    localparam int GW = $clog2(GAP + 1);

    localparam logic [63:0] MSG_IDLE   = "IDLE    ";
    localparam logic [63:0] MSG_CALLER = "CALLER  ";
    localparam logic [63:0] MSG_CALLEE = "CALLEE  ";

    typedef enum logic {
        ST_READY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Index 0 is the caller side, index 1 the callee side throughout.
    logic [1:0]    valid_w;
    logic [7:0]    char_w  [2];
    logic [1:0]    ready_w;
    logic [CW-1:0] count_w [2];
    logic [7:0]    head_w  [2];
    logic [1:0]    eligible;
    logic [1:0]    pop;
    logic          flush;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    charSent_q, charSent_d;
    logic [1:0]    strobe_q, strobe_d;

    assign valid_w   = {calleeValid_i, callerValid_i};
    assign char_w[0] = callerChar_i;
    assign char_w[1] = calleeChar_i;

    assign flush       = (statusMsg_i == MSG_IDLE);
    assign eligible[0] = (statusMsg_i == MSG_CALLER);
    assign eligible[1] = (statusMsg_i == MSG_CALLEE);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [7:0]    mem [DEPTH];
            logic [AW-1:0] wr_ptr_q, wr_ptr_d;
            logic [AW-1:0] rd_ptr_q, rd_ptr_d;
            logic [CW-1:0] count_q, count_d;
            logic          push;

            // A full FIFO refuses the write even if the same edge pops it.
            assign ready_w[gi] = (count_q != CW'(DEPTH));
            assign push        = valid_w[gi] && ready_w[gi] && !flush;
            assign head_w[gi]  = mem[rd_ptr_q];
            assign count_w[gi] = count_q;

            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_q] <= char_w[gi];
                end
            end

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (flush) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (pop[gi]) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                    if (push && !pop[gi]) begin
                        count_d = count_q + 1'b1;
                    end else if (!push && pop[gi]) begin
                        count_d = count_q - 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // Turns are mutually exclusive, so at most one side pops per cycle.
            assign pop[gi] = (state_q == ST_READY) && !flush && eligible[gi] &&
                             (count_w[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_READY;
            gap_q      <= '0;
            charSent_q <= 8'd0;
            strobe_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            charSent_q <= charSent_d;
            strobe_q   <= strobe_d;
        end
    end

    // HOLD spans GAP cycles after a strobe so a turn change reported by tel
    // (which shows up in statusMsg two cycles late) is seen before the next issue.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        if (flush) begin
            state_d = ST_READY;
            gap_d   = '0;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (|pop) begin
                        state_d = ST_HOLD;
                        gap_d   = GW'(GAP);
                    end
                end
                ST_HOLD: begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q <= GW'(1)) begin
                        state_d = ST_READY;
                        gap_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_READY;
                    gap_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        strobe_d   = pop;
        charSent_d = charSent_q;
        if (pop[0]) begin
            charSent_d = head_w[0];
        end else if (pop[1]) begin
            charSent_d = head_w[1];
        end
    end

    assign callerReady_o    = ready_w[0];
    assign calleeReady_o    = ready_w[1];
    assign callerCount_o    = count_w[0];
    assign calleeCount_o    = count_w[1];
    assign charSent_o       = charSent_q;
    assign sendCharCaller_o = strobe_q[0];
    assign sendCharCallee_o = strobe_q[1];

endmodule

// File: tb/tb_tel_char_feeder.sv
// Bench for tel_char_feeder: directed scenarios plus randomized turns, each checked
// against per-side character queues that describe the expected strobe sequence.
module tb_tel_char_feeder;

    localparam int DEPTH = 8;
    localparam int GAP   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [63:0] S_IDLE    = "IDLE    ";
    localparam logic [63:0] S_CALLER  = "CALLER  ";
    localparam logic [63:0] S_CALLEE  = "CALLEE  ";
    localparam logic [63:0] S_RINGING = "RINGING ";

    logic          clk = 1'b0;
    logic          rst;
    logic          callerValid, calleeValid;
    logic [7:0]    callerChar, calleeChar;
    logic          callerReady, calleeReady;
    logic [63:0]   statusMsg;
    logic [7:0]    charSent;
    logic          sendCaller, sendCallee;
    logic [CW-1:0] callerCount, calleeCount;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Strobes seen by the monitor: side 0 caller, 1 callee, 2 both (illegal).
    int         obs_side [$];
    logic [7:0] obs_char [$];
    int         obs_cyc  [$];

    tel_char_feeder #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk              (clk),
        .rst              (rst),
        .callerValid_i    (callerValid),
        .callerChar_i     (callerChar),
        .callerReady_o    (callerReady),
        .calleeValid_i    (calleeValid),
        .calleeChar_i     (calleeChar),
        .calleeReady_o    (calleeReady),
        .statusMsg_i      (statusMsg),
        .charSent_o       (charSent),
        .sendCharCaller_o (sendCaller),
        .sendCharCallee_o (sendCallee),
        .callerCount_o    (callerCount),
        .calleeCount_o    (calleeCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sendCaller || sendCallee) begin
            obs_side.push_back((sendCaller && sendCallee) ? 2 : (sendCallee ? 1 : 0));
            obs_char.push_back(charSent);
            obs_cyc.push_back(cyc);
            $display("strobe cyc=%0d caller=%0b callee=%0b char=0x%02h",
                     cyc, sendCaller, sendCallee, charSent);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        callerValid = 1'b0;
        calleeValid = 1'b0;
        statusMsg   = S_IDLE;
        repeat (2) tick();
        obs_side.delete();
        obs_char.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        callerValid = 1'b0;
        calleeValid = 1'b0;
        callerChar  = 8'd0;
        calleeChar  = 8'd0;
        statusMsg   = S_IDLE;
        repeat (2) tick();
        checks++; if (charSent !== 8'd0) begin errors++; $display("FAIL reset_char got=%h exp=00", charSent); end
        checks++; if ({sendCaller, sendCallee} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", sendCaller, sendCallee); end
        checks++; if (callerCount !== CW'(0) || calleeCount !== CW'(0)) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", callerCount, calleeCount); end
        checks++; if ({callerReady, calleeReady} !== 2'b11) begin errors++; $display("FAIL reset_ready got=%b%b exp=11", callerReady, calleeReady); end
        #2 rst = 1'b0;
        tick();
        checks++; if (callerCount !== CW'(0) || sendCaller !== 1'b0) begin errors++; $display("FAIL post_reset got count=%0d strobe=%b exp=0/0", callerCount, sendCaller); end
    endtask

    task automatic test_caller_basic();
        logic [7:0] chars [$];
        int push_cyc;
        chars = '{8'h41, 8'h42, 8'h35};
        push_cyc = 0;
        settle();
        statusMsg = S_CALLER;
        tick();
        for (int i = 0; i < chars.size(); i++) begin
            callerValid = 1'b1;
            callerChar  = chars[i];
            tick();
            if (i == 0) push_cyc = cyc;
        end
        callerValid = 1'b0;
        repeat (15) tick();
        checks++; if (obs_side.size() != chars.size()) begin errors++; $display("FAIL basic_num got=%0d exp=%0d", obs_side.size(), chars.size()); end
        for (int i = 0; i < obs_side.size() && i < chars.size(); i++) begin
            checks++; if (obs_char[i] !== chars[i] || obs_side[i] != 0) begin errors++; $display("FAIL basic_char[%0d] got=%h side=%0d exp=%h side=0", i, obs_char[i], obs_side[i], chars[i]); end
            if (i > 0) begin
                checks++; if (obs_cyc[i] - obs_cyc[i-1] != GAP + 1) begin errors++; $display("FAIL basic_spacing[%0d] got=%0d exp=%0d", i, obs_cyc[i] - obs_cyc[i-1], GAP + 1); end
            end
        end
        if (obs_cyc.size() > 0) begin
            checks++; if (obs_cyc[0] != push_cyc + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", obs_cyc[0], push_cyc + 1); end
        end
    endtask

    task automatic test_handoff();
        int         exp_side [$];
        logic [7:0] exp_char [$];
        bit         found;
        exp_side = '{0, 0, 1, 1};
        exp_char = '{8'h48, 8'h7F, 8'h4F, 8'h4B};
        found = 1'b0;
        settle();
        statusMsg = S_RINGING;
        callerValid = 1'b1; calleeValid = 1'b1;
        callerChar = 8'h48; calleeChar = 8'h4F;
        tick();
        callerChar = 8'h7F; calleeChar = 8'h4B;
        tick();
        callerValid = 1'b0; calleeValid = 1'b0;
        statusMsg = S_CALLER;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (sendCaller === 1'b1 && charSent === 8'h7F) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL handoff_del got=none exp=7f strobe"); end
        repeat (2) tick();
        statusMsg = S_CALLEE;
        repeat (12) tick();
        checks++; if (obs_side.size() != exp_side.size()) begin errors++; $display("FAIL handoff_num got=%0d exp=%0d", obs_side.size(), exp_side.size()); end
        for (int i = 0; i < obs_side.size() && i < exp_side.size(); i++) begin
            checks++; if (obs_side[i] != exp_side[i] || obs_char[i] !== exp_char[i]) begin errors++; $display("FAIL handoff[%0d] got side=%0d char=%h exp side=%0d char=%h", i, obs_side[i], obs_char[i], exp_side[i], exp_char[i]); end
        end
        if (obs_cyc.size() >= 3) begin
            checks++; if (obs_cyc[2] - obs_cyc[1] != GAP + 1) begin errors++; $display("FAIL handoff_gap got=%0d exp=%0d", obs_cyc[2] - obs_cyc[1], GAP + 1); end
        end
    endtask

    task automatic test_full();
        logic [7:0] model [$];
        logic [7:0] c;
        bit         acc;
        settle();
        statusMsg = S_RINGING;
        for (int i = 0; i < DEPTH + 2; i++) begin
            c = 8'($urandom);
            acc = (model.size() < DEPTH);
            callerValid = 1'b1;
            callerChar  = c;
            tick();
            if (acc) model.push_back(c);
            checks++; if (callerCount !== CW'(model.size())) begin errors++; $display("FAIL full_count[%0d] got=%0d exp=%0d", i, callerCount, model.size()); end
            checks++; if (callerReady !== (model.size() != DEPTH)) begin errors++; $display("FAIL full_ready[%0d] got=%b exp=%b", i, callerReady, model.size() != DEPTH); end
        end
        callerValid = 1'b0;
        statusMsg = S_CALLER;
        repeat (DEPTH * (GAP + 1) + 8) tick();
        checks++; if (obs_side.size() != model.size()) begin errors++; $display("FAIL full_num got=%0d exp=%0d", obs_side.size(), model.size()); end
        for (int i = 0; i < obs_side.size() && i < model.size(); i++) begin
            checks++; if (obs_char[i] !== model[i] || obs_side[i] != 0) begin errors++; $display("FAIL full_order[%0d] got=%h side=%0d exp=%h side=0", i, obs_char[i], obs_side[i], model[i]); end
        end
    endtask

    task automatic test_flush();
        settle();
        statusMsg = S_RINGING;
        for (int i = 0; i < 3; i++) begin
            callerValid = 1'b1; calleeValid = 1'b1;
            callerChar = 8'($urandom); calleeChar = 8'($urandom);
            tick();
        end
        checks++; if (callerCount !== CW'(3) || calleeCount !== CW'(3)) begin errors++; $display("FAIL flush_pre got=%0d/%0d exp=3/3", callerCount, calleeCount); end
        statusMsg = S_IDLE;
        callerChar = 8'($urandom); calleeChar = 8'($urandom);
        tick();
        callerValid = 1'b0; calleeValid = 1'b0;
        statusMsg = S_RINGING;
        checks++; if (callerCount !== CW'(0) || calleeCount !== CW'(0)) begin errors++; $display("FAIL flush_counts got=%0d/%0d exp=0/0", callerCount, calleeCount); end
        checks++; if ({callerReady, calleeReady} !== 2'b11) begin errors++; $display("FAIL flush_ready got=%b%b exp=11", callerReady, calleeReady); end
        statusMsg = S_CALLER;
        repeat (8) tick();
        statusMsg = S_CALLEE;
        repeat (8) tick();
        checks++; if (obs_side.size() != 0) begin errors++; $display("FAIL flush_strobes got=%0d exp=0", obs_side.size()); end
    endtask

    task automatic test_push_pop();
        logic [7:0] model [$];
        settle();
        statusMsg = S_RINGING;
        for (int i = 0; i < DEPTH - 1; i++) begin
            model.push_back(8'($urandom));
            callerValid = 1'b1;
            callerChar  = model[i];
            tick();
        end
        checks++; if (callerCount !== CW'(DEPTH - 1)) begin errors++; $display("FAIL pp_pre got=%0d exp=%0d", callerCount, DEPTH - 1); end
        model.push_back(8'($urandom));
        callerChar = model[DEPTH - 1];
        statusMsg  = S_CALLER;
        tick();
        callerValid = 1'b0;
        checks++; if (callerCount !== CW'(DEPTH - 1)) begin errors++; $display("FAIL pp_count got=%0d exp=%0d", callerCount, DEPTH - 1); end
        checks++; if (sendCaller !== 1'b1 || charSent !== model[0]) begin errors++; $display("FAIL pp_pop got strobe=%b char=%h exp strobe=1 char=%h", sendCaller, charSent, model[0]); end
        repeat (DEPTH * (GAP + 1) + 8) tick();
        checks++; if (obs_side.size() != model.size()) begin errors++; $display("FAIL pp_num got=%0d exp=%0d", obs_side.size(), model.size()); end
        for (int i = 0; i < obs_side.size() && i < model.size(); i++) begin
            checks++; if (obs_char[i] !== model[i] || obs_side[i] != 0) begin errors++; $display("FAIL pp_order[%0d] got=%h exp=%h", i, obs_char[i], model[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] q_caller [$];
        logic [7:0] q_callee [$];
        int         exp_side [$];
        logic [7:0] exp_char [$];
        int         n0, n1, pre0, pre1;
        for (int it = 0; it < 4; it++) begin
            settle();
            q_caller.delete(); q_callee.delete();
            exp_side.delete(); exp_char.delete();
            n0   = $urandom_range(1, DEPTH);
            n1   = $urandom_range(1, DEPTH);
            pre0 = $urandom_range(0, n0);
            pre1 = $urandom_range(0, n1);
            statusMsg = S_RINGING;
            for (int c = 0; c < 30; c++) begin
                callerValid = (q_caller.size() < pre0) && ($urandom_range(0, 1) == 1);
                calleeValid = (q_callee.size() < pre1) && ($urandom_range(0, 1) == 1);
                callerChar  = 8'($urandom);
                calleeChar  = 8'($urandom);
                tick();
                if (callerValid) q_caller.push_back(callerChar);
                if (calleeValid) q_callee.push_back(calleeChar);
            end
            statusMsg = S_CALLER;
            for (int c = 0; c < 40; c++) begin
                callerValid = (q_caller.size() < n0) && ($urandom_range(0, 2) == 0);
                calleeValid = (q_callee.size() < n1) && ($urandom_range(0, 2) == 0);
                callerChar  = 8'($urandom);
                calleeChar  = 8'($urandom);
                tick();
                if (callerValid) q_caller.push_back(callerChar);
                if (calleeValid) q_callee.push_back(calleeChar);
            end
            callerValid = 1'b0; calleeValid = 1'b0;
            repeat (DEPTH * (GAP + 1) + 4) tick();
            statusMsg = S_CALLEE;
            repeat (DEPTH * (GAP + 1) + 4) tick();
            foreach (q_caller[i]) begin exp_side.push_back(0); exp_char.push_back(q_caller[i]); end
            foreach (q_callee[i]) begin exp_side.push_back(1); exp_char.push_back(q_callee[i]); end
            checks++; if (obs_side.size() != exp_side.size()) begin errors++; $display("FAIL rand%0d_num got=%0d exp=%0d", it, obs_side.size(), exp_side.size()); end
            for (int i = 0; i < obs_side.size() && i < exp_side.size(); i++) begin
                checks++; if (obs_side[i] != exp_side[i] || obs_char[i] !== exp_char[i]) begin errors++; $display("FAIL rand%0d[%0d] got side=%0d char=%h exp side=%0d char=%h", it, i, obs_side[i], obs_char[i], exp_side[i], exp_char[i]); end
                if (i > 0) begin
                    checks++; if (obs_cyc[i] - obs_cyc[i-1] < GAP + 1) begin errors++; $display("FAIL rand%0d_spacing[%0d] got=%0d exp>=%0d", it, i, obs_cyc[i] - obs_cyc[i-1], GAP + 1); end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] c;
        bit         found;
        found = 1'b0;
        settle();
        statusMsg = S_CALLER;
        for (int i = 0; i < 4; i++) begin
            callerValid = 1'b1;
            callerChar  = 8'($urandom);
            tick();
        end
        callerValid = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (sendCaller === 1'b1) found = 1'b1;
            else tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL areset_strobe got=none exp=strobe"); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({sendCaller, sendCallee} !== 2'b00) begin errors++; $display("FAIL areset_strobes got=%b%b exp=00", sendCaller, sendCallee); end
        checks++; if (callerCount !== CW'(0) || calleeCount !== CW'(0)) begin errors++; $display("FAIL areset_counts got=%0d/%0d exp=0/0", callerCount, calleeCount); end
        checks++; if (charSent !== 8'd0) begin errors++; $display("FAIL areset_char got=%h exp=00", charSent); end
        #2 rst = 1'b0;
        obs_side.delete(); obs_char.delete(); obs_cyc.delete();
        c = 8'($urandom);
        callerValid = 1'b1;
        callerChar  = c;
        tick();
        callerValid = 1'b0;
        tick();
        checks++; if (sendCaller !== 1'b1 || charSent !== c) begin errors++; $display("FAIL areset_ready got strobe=%b char=%h exp strobe=1 char=%h", sendCaller, charSent, c); end
        repeat (10) tick();
        checks++; if (obs_side.size() != 1) begin errors++; $display("FAIL areset_num got=%0d exp=1", obs_side.size()); end
    endtask

    initial begin
        test_reset();
        test_caller_basic();
        test_handoff();
        test_full();
        test_flush();
        test_push_pop();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tel_char_feeder.md
# tel_char_feeder

Upstream input stage of the phone-conversation design. It buffers characters typed on the caller and callee keypads in two independent FIFOs and paces them out as `charSent` plus a one-cycle `sendCharCaller` / `sendCharCallee` strobe to the `tel` controller. It drains only the FIFO of the side whose turn it currently is, using `tel`'s registered `statusMsg`. The FIFOs are flushed whenever the phone is idle.

## Interface
- `DEPTH`, 8 — entries per FIFO; power of two, ≥2.
- `GAP`, 2 — idle cycles enforced after every strobe; ≥2.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `callerValid` in 1 — caller keypad offers `callerChar`.
- `callerChar` in 8 — caller character.
- `callerReady` out 1 — caller FIFO can accept.
- `calleeValid` in 1 — callee keypad offers `calleeChar`.
- `calleeChar` in 8 — callee character.
- `calleeReady` out 1 — callee FIFO can accept.
- `statusMsg` in 64 — `tel` status string (8 ASCII chars, MSB first).
- `charSent` out 8 — character presented to `tel`.
- `sendCharCaller` out 1 — one-cycle strobe: `charSent` is from the caller.
- `sendCharCallee` out 1 — one-cycle strobe: `charSent` is from the callee.
- `callerCount` out log2(DEPTH)+1 — caller FIFO occupancy.
- `calleeCount` out log2(DEPTH)+1 — callee FIFO occupancy.

## Operation
- Push: a side's write occurs on a clock edge when both `xValid` and `xReady` are high. `xReady` = (`xCount` != DEPTH), derived from registered count. A full FIFO gets no same-cycle pop bypass.
- Characters are stored unfiltered. `tel` discards out-of-range codes; DEL (127) is stored like any other character.
- Turn decode from `statusMsg`:
  - "CALLER  " → caller FIFO eligible.
  - "CALLEE  " → callee FIFO eligible.
  - any other value → nothing eligible.
- Flush: while `statusMsg` == "IDLE    ", both counts and pointers are cleared and the gap counter is cleared. Pushes in that cycle are discarded. `xReady` stays high.
- Issue FSM states:
  - READY: if the eligible FIFO is non-empty, pop its head, drive `charSent` with it, pulse the matching strobe for one cycle, then go to HOLD with gap counter = GAP.
  - HOLD: decrement the gap counter each cycle; return to READY when it reaches 0. No strobe is issued in HOLD.
- Exactly one of `sendCharCaller` / `sendCharCallee` may be high in any cycle; never both.
- A simultaneous push and pop on the same FIFO in the same cycle leaves its count unchanged and keeps data order intact.
- Pointers wrap modulo DEPTH.
- `charSent` holds its last issued value between strobes.

## Timing
- Reset values:
  - `charSent` = 8'd0.
  - both strobes = 0.
  - counts = 0.
  - both `xReady` = 1.
  - FSM = READY, gap counter = 0.
- All outputs are registered except `xReady`, which is combinational from the registered count.
- Latency: a char pushed at edge t into an empty eligible FIFO while in READY appears with its strobe in cycle t+1.
- Minimum strobe spacing is GAP+1 cycles.
- GAP ≥ 2 is required because `statusMsg` lags `tel`'s state by one cycle:
  - a DEL strobe in cycle t moves `tel` to the other side in t+1;
  - `statusMsg` shows the new side in t+2;
  - the next issue decision, made at the end of t+GAP, therefore sees the new turn.
- If a call ends (`statusMsg` leaves CALLER/CALLEE) while chars are queued, issuing stops and the data is kept until "IDLE    " flushes it.
- If `rst` is asserted mid-operation, all state returns to the reset values immediately, regardless of the clock.

## Test plan
- Reset, then `statusMsg`="CALLER  " and push 'A','B','5' on the caller side → strobes with `charSent`=0x41, 0x42, 0x35, each strobe 3 cycles apart (GAP=2); `sendCharCallee` stays 0 throughout.
- Turn handoff: `statusMsg`="CALLER  " with caller queue 'H',0x7F and callee queue 'O','K'. Switch `statusMsg` to "CALLEE  " 2 cycles after the 0x7F strobe → callee emits 'O' (0x4F) then 'K' (0x4B); no caller strobe after 0x7F.
- Full FIFO: `statusMsg`="RINGING ", push DEPTH+2 caller chars → `callerCount`=8, `callerReady`=0 after the 8th push, extra chars dropped. Then switch to "CALLER  " → exactly 8 strobes in push order.
- Flush: queue 3 chars on each side, set `statusMsg`="IDLE    " for one cycle → both counts are 0 the next cycle and no strobe is issued; a push in the flush cycle is not stored.
- Push-during-pop: with the caller FIFO at DEPTH−1, push one char on the same edge as a pop → count stays DEPTH−1 and order is preserved.
- Async reset mid-burst: assert `rst` between two strobes → strobes drop to 0 and counts to 0 without a clock edge; after release, the FSM is in READY.
